pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer: the next-generation branch unit for the core. It owns the PC register and evaluates conditional and unconditional branches on a DATA_W operand, redirecting to PC + ALU offset. It also maintains an optional return-address stack for CALL/RET. It emits a flush window after every taken redirect so fetch/decode can squash wrong-path instructions. It sits between the ALU/register read stage and instruction fetch.

## Interface
- DATA_W, 8, width of the tested operand
- PC_W, 8, width of PC and offset
- RAS_DEPTH, 4, return-address stack entries (≥1); ignored when RAS_EN is undefined
- FLUSH_LEN, 1, flush window length in cycles (≥1)
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  hold all state (PC, stack, flush counter) this cycle
- valid  in  1  op is a real instruction; 0 treated as NONE
- op  in  3  000 NONE, 001 BEZ, 010 BNZ, 011 BLTZ, 100 JA, 101 CALL, 110 RET, 111 NONE
- x  in  DATA_W  operand tested by BEZ/BNZ/BLTZ
- off  in  PC_W  ALU output, two's-complement branch offset
- pc  out  PC_W  current PC (registered)
- taken  out  1  registered one-cycle pulse: previous accepted op redirected
- flush  out  1  high for FLUSH_LEN unstalled cycles after a redirect
- ras_ovf  out  1  registered one-cycle pulse: CALL pushed into a full stack
- ras_unf  out  1  registered one-cycle pulse: RET on an empty stack

## Operation
- Accepted cycle: reset_n=1, stall=0, valid=1, flush=0. Otherwise the effective op is NONE.
- Conditions:
  - BEZ: x==0
  - BNZ: x!=0
  - BLTZ: x[DATA_W-1]==1
  - JA and CALL: always taken
- Taken branch/JA/CALL target: pc + off, modulo 2^PC_W (wraps, no error).
- Not taken / NONE: pc + 1, modulo 2^PC_W. 0xFF+1 → 0x00 at PC_W=8.
- CALL: push pc+1, jump to target.
  - Stack full: overwrite oldest entry (circular), count stays RAS_DEPTH, pulse ras_ovf.
- RET, stack non-empty: pop top, pc ← popped value, taken.
- RET, stack empty: pc ← pc+1, not taken, pulse ras_unf.
- Flush counter:
  - Loaded with FLUSH_LEN on any taken redirect.
  - Decrements on each unstalled cycle.
  - flush = (counter != 0). While it is set, ops are ignored and pc advances +1 per unstalled cycle.
- stall=1: pc, stack, counter and count all hold. taken/ras_ovf/ras_unf are 0 that cycle.

## Timing
- Decision is combinational from the current-cycle inputs; pc updates at the following edge. Latency is 1 cycle from op to new pc.
- taken, ras_ovf and ras_unf assert in the same cycle the new pc is visible, for exactly one cycle.
- flush rises with taken and stays high for FLUSH_LEN unstalled cycles. Stalled cycles extend it.
- Reset (reset_n=0 at an edge), including mid-flush or mid-stall, gives:
  - pc=RESET_PC
  - stack count=0
  - flush counter=0
  - taken, flush, ras_ovf, ras_unf = 0
- Reset overrides stall.
- First accepted op is the cycle after reset_n returns high.

## Configuration
- RAS_EN defined: return-address stack built as described; RAS_DEPTH applies.
- RAS_EN undefined:
  - No stack storage.
  - CALL behaves exactly as JA (no push).
  - RET behaves as NONE (pc+1, not taken).
  - ras_ovf and ras_unf are tied to 0.

## Test plan
- Reset, then 3 cycles of NONE → pc 0,1,2,3. Hold reset_n=0 mid-sequence → pc returns to 0 next edge, flush=0.
- pc=0x10, BEZ with x=0, off=0x05 → pc=0x15, taken=1, flush high 1 cycle.
  - Same op with x=0x01 → pc=0x11, taken=0.
  - BLTZ with x=0x80, off=0xFE → pc=0x0E.
- pc=0xFF, NONE → pc=0x00. pc=0xFE, JA off=0x03 → pc=0x01 (wrap).
- RAS_EN, RAS_DEPTH=2:
  - CALL at pc 0x10 (off 0x10) → pc 0x20.
  - CALL at pc 0x20 (off 0x10) → pc 0x30.
  - CALL at pc 0x30 (off 0x10) → pc 0x40, ras_ovf=1.
  - RET ×2 → pc 0x31 then 0x21.
  - Third RET → pc+1, ras_unf=1, taken=0.
- FLUSH_LEN=2: taken JA, then stall=1 for 2 cycles, then BEZ x=0 presented each cycle → flush stays high through the stalls and 2 unstalled cycles, BEZ ignored while flush=1, accepted on the first cycle after flush drops.
- RAS_EN undefined: CALL off=0x04 at pc 0x08 → pc 0x0C. RET → pc 0x0D, taken=0, ras_unf=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/jump/call/return redirect with a post-redirect flush window.
// Optional return-address stack is built only when RAS_EN is defined.
module pc_sequencer #(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int FLUSH_LEN = 1,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] x,
  input  logic [PC_W-1:0]   off,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              flush,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEZ  = 3'b001;
  localparam logic [2:0] OP_BNZ  = 3'b010;
  localparam logic [2:0] OP_BLTZ = 3'b011;
  localparam logic [2:0] OP_JA   = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam int FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN + 1) : 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            taken_q, taken_d;
  logic            accept;
  logic [2:0]      op_eff;
  logic [PC_W-1:0] pc_inc, pc_tgt, ras_top;
  logic            cond_taken, ret_hit;

  assign accept = reset_n && !stall && valid && (fc_q == '0);
  assign op_eff = accept ? op : OP_NONE;
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = pc_q + off;

  always_comb begin
    cond_taken = 1'b0;
    case (op_eff)
      OP_BEZ:  cond_taken = (x == '0);
      OP_BNZ:  cond_taken = (x != '0);
      OP_BLTZ: cond_taken = x[DATA_W-1];
      OP_JA:   cond_taken = 1'b1;
      OP_CALL: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

`ifdef RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, ras_full, ras_empty;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  // sp_q points at the next free slot; the ring overwrites the oldest entry when full
  assign sp_inc    = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
  assign sp_dec    = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - PTR_W'(1);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_mem_q[sp_dec];
  assign push      = (op_eff == OP_CALL);
  assign ret_hit   = (op_eff == OP_RET) && !ras_empty;
  assign ovf_d     = push && ras_full;
  assign unf_d     = (op_eff == OP_RET) && ras_empty;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d  = sp_inc;
      cnt_d = ras_full ? cnt_q : cnt_q + CNT_W'(1);
    end else if (ret_hit) begin
      sp_d  = sp_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem_q[sp_q] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  logic [31:0] unused_ras_depth;
  assign unused_ras_depth = RAS_DEPTH;
  assign ret_hit = 1'b0;
  assign ras_top = '0;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  assign taken_d = cond_taken | ret_hit;

  always_comb begin
    pc_d = pc_q;
    fc_d = fc_q;
    if (!stall) begin
      if (ret_hit)         pc_d = ras_top;
      else if (cond_taken) pc_d = pc_tgt;
      else                 pc_d = pc_inc;
      // a redirect can only happen with the counter already at zero
      if (taken_d)            fc_d = FC_W'(FLUSH_LEN);
      else if (fc_q != '0)    fc_d = fc_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= PC_W'(RESET_PC);
      fc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fc_q    <= fc_d;
      taken_q <= taken_d;
    end
  end

  assign pc    = pc_q;
  assign taken = taken_q;
  assign flush = (fc_q != '0);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (FLUSH_LEN=2, RAS_DEPTH=2): directed vector table, then random ops
// checked against a queue-based reference model. RAS_EN selects the stack expectations.
module tb_pc_sequencer;

  localparam int FL = 2;
  localparam int RD = 2;

  logic       clk = 1'b0;
  logic       reset_n, stall, valid;
  logic [2:0] op;
  logic [7:0] x, off;
  logic [7:0] pc;
  logic       taken, flush, ras_ovf, ras_unf;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .DATA_W(8), .PC_W(8), .RAS_DEPTH(RD), .FLUSH_LEN(FL), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .valid(valid), .op(op),
    .x(x), .off(off), .pc(pc), .taken(taken), .flush(flush),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n, stl, vld;
    bit [2:0] o;
    bit [7:0] xx, of, e_pc;
    bit       e_tk, e_fl, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit s, bit v, bit [2:0] o, bit [7:0] xx, bit [7:0] of,
                              bit [7:0] epc, bit etk, bit efl, bit eovf, bit eunf);
    vec_t t;
    t.rst_n = r; t.stl = s; t.vld = v; t.o = o; t.xx = xx; t.of = of;
    t.e_pc = epc; t.e_tk = etk; t.e_fl = efl; t.e_ovf = eovf; t.e_unf = eunf;
    vecs.push_back(t);
  endfunction

  // reference model state
  int m_pc, m_fc;
  bit m_tk, m_ovf, m_unf;
  int m_ras[$];

  function automatic void model_step(bit r, bit s, bit v, bit [2:0] o, bit [7:0] xx, bit [7:0] of);
    int nxt;
    bit red;
    m_tk = 0; m_ovf = 0; m_unf = 0;
    if (!r) begin
      m_pc = 0; m_fc = 0; m_ras.delete();
      return;
    end
    if (s) return;
    nxt = (m_pc + 1) % 256;
    red = 0;
    if (v && m_fc == 0) begin
      case (o)
        3'd1: red = (xx == 0);
        3'd2: red = (xx != 0);
        3'd3: red = (xx >= 128);
        3'd4: red = 1;
        3'd5: begin
          red = 1;
`ifdef RAS_EN
          if (m_ras.size() == RD) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back(nxt);
`endif
        end
        3'd6: begin
`ifdef RAS_EN
          if (m_ras.size() > 0) begin
            nxt = m_ras.pop_back();
            m_tk = 1;
          end else m_unf = 1;
`endif
        end
        default: red = 0;
      endcase
    end
    if (red) begin
      nxt = (m_pc + of) % 256;
      m_tk = 1;
    end
    if (m_fc > 0) m_fc--;
    else if (m_tk) m_fc = FL;
    m_pc = nxt;
  endfunction

  task automatic drive(input bit r, input bit s, input bit v, input bit [2:0] o,
                       input bit [7:0] xx, input bit [7:0] of);
    reset_n = r; stall = s; valid = v; op = o; x = xx; off = of;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit [7:0] epc, input bit etk, input bit efl,
                         input bit eovf, input bit eunf);
    chk({tag, ".pc"}, 32'(pc), 32'(epc));
    chk({tag, ".taken"}, 32'(taken), 32'(etk));
    chk({tag, ".flush"}, 32'(flush), 32'(efl));
    chk({tag, ".ras_ovf"}, 32'(ras_ovf), 32'(eovf));
    chk({tag, ".ras_unf"}, 32'(ras_unf), 32'(eunf));
  endtask

  initial begin
    reset_n = 0; stall = 0; valid = 0; op = 3'd0; x = 8'h00; off = 8'h00;

    //  rst stl vld op    x      off    pc    tk fl ov un
    add(0, 0, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h03, 0, 0, 0, 0);
    add(0, 0, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 1, 3'd4, 8'h00, 8'h10, 8'h10, 1, 1, 0, 0);
    add(1, 0, 1, 3'd1, 8'h00, 8'h05, 8'h11, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 0);
    add(1, 0, 1, 3'd4, 8'h00, 8'hFC, 8'h0E, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h0F, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0);
    add(1, 0, 1, 3'd1, 8'h00, 8'h05, 8'h15, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h16, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h17, 0, 0, 0, 0);
    add(1, 0, 1, 3'd1, 8'h01, 8'h05, 8'h18, 0, 0, 0, 0);
    add(1, 0, 1, 3'd3, 8'h80, 8'hFE, 8'h16, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h17, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h18, 0, 0, 0, 0);
    add(1, 0, 1, 3'd2, 8'h00, 8'h05, 8'h19, 0, 0, 0, 0);
    add(1, 0, 1, 3'd2, 8'h03, 8'h10, 8'h29, 1, 1, 0, 0);
    add(1, 0, 0, 3'd4, 8'h00, 8'h40, 8'h2A, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h2B, 0, 0, 0, 0);
    add(1, 0, 1, 3'd3, 8'h7F, 8'h40, 8'h2C, 0, 0, 0, 0);
    add(1, 0, 1, 3'd4, 8'h00, 8'hD1, 8'hFD, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'hFE, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 3'd4, 8'h00, 8'h40, 8'h01, 0, 0, 0, 0);
    add(1, 0, 1, 3'd7, 8'h00, 8'h40, 8'h02, 0, 0, 0, 0);
    add(1, 0, 1, 3'd4, 8'h00, 8'hFA, 8'hFC, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'hFD, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'hFE, 0, 0, 0, 0);
    add(1, 0, 1, 3'd4, 8'h00, 8'h03, 8'h01, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h02, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h03, 0, 0, 0, 0);
    // flush window stretched by stalls, BEZ held on the bus throughout
    add(1, 0, 1, 3'd4, 8'h00, 8'h05, 8'h08, 1, 1, 0, 0);
    add(1, 1, 1, 3'd1, 8'h00, 8'h20, 8'h08, 0, 1, 0, 0);
    add(1, 1, 1, 3'd1, 8'h00, 8'h20, 8'h08, 0, 1, 0, 0);
    add(1, 0, 1, 3'd1, 8'h00, 8'h20, 8'h09, 0, 1, 0, 0);
    add(1, 0, 1, 3'd1, 8'h00, 8'h20, 8'h0A, 0, 0, 0, 0);
    add(1, 0, 1, 3'd1, 8'h00, 8'h20, 8'h2A, 1, 1, 0, 0);
    add(0, 1, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);
`ifdef RAS_EN
    add(1, 0, 1, 3'd4, 8'h00, 8'h0D, 8'h0E, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h0F, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0);
    add(1, 0, 1, 3'd5, 8'h00, 8'h10, 8'h20, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h21, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h22, 0, 0, 0, 0);
    add(1, 0, 1, 3'd5, 8'h00, 8'h10, 8'h32, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h33, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h34, 0, 0, 0, 0);
    add(1, 0, 1, 3'd5, 8'h00, 8'h10, 8'h44, 1, 1, 1, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h45, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h46, 0, 0, 0, 0);
    add(1, 0, 1, 3'd6, 8'h00, 8'h00, 8'h35, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h36, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h37, 0, 0, 0, 0);
    add(1, 0, 1, 3'd6, 8'h00, 8'h00, 8'h23, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h24, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h25, 0, 0, 0, 0);
    add(1, 0, 1, 3'd6, 8'h00, 8'h00, 8'h26, 0, 0, 0, 1);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h27, 0, 0, 0, 0);
`else
    add(1, 0, 1, 3'd4, 8'h00, 8'h05, 8'h06, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h07, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h08, 0, 0, 0, 0);
    add(1, 0, 1, 3'd5, 8'h00, 8'h04, 8'h0C, 1, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h0D, 0, 1, 0, 0);
    add(1, 0, 1, 3'd0, 8'h00, 8'h00, 8'h0E, 0, 0, 0, 0);
    add(1, 0, 1, 3'd6, 8'h00, 8'h00, 8'h0F, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      t = vecs[i];
      drive(t.rst_n, t.stl, t.vld, t.o, t.xx, t.of);
      chk_all($sformatf("vec%0d", i), t.e_pc, t.e_tk, t.e_fl, t.e_ovf, t.e_unf);
      $display("[TB] vec %0d rst_n=%0b stall=%0b op=%0d x=%02h off=%02h -> pc=%02h taken=%0b flush=%0b ovf=%0b unf=%0b",
               i, t.rst_n, t.stl, t.o, t.xx, t.of, pc, taken, flush, ras_ovf, ras_unf);
    end

    // random phase: both sides start from reset
    model_step(0, 0, 0, 3'd0, 8'h00, 8'h00);
    drive(0, 0, 0, 3'd0, 8'h00, 8'h00);
    chk_all("rnd_reset", 8'(m_pc), m_tk, (m_fc != 0), m_ovf, m_unf);
    for (int n = 0; n < 1500; n++) begin
      bit r, s, v;
      bit [2:0] o;
      bit [7:0] xx, of;
      int sel;
      r  = ($urandom_range(0, 99) >= 2);
      s  = ($urandom_range(0, 99) < 15);
      v  = ($urandom_range(0, 99) < 85);
      o  = 3'($urandom_range(0, 7));
      of = 8'($urandom);
      sel = $urandom_range(0, 2);
      xx = (sel == 0) ? 8'h00 : (sel == 1) ? 8'($urandom) : (8'h80 | 8'($urandom));
      model_step(r, s, v, o, xx, of);
      drive(r, s, v, o, xx, of);
      chk_all($sformatf("rnd%0d", n), 8'(m_pc), m_tk, (m_fc != 0), m_ovf, m_unf);
      $display("[TB] rnd %0d rst_n=%0b stall=%0b valid=%0b op=%0d x=%02h off=%02h -> pc=%02h (model %02h) taken=%0b flush=%0b",
               n, r, s, v, o, xx, of, pc, 8'(m_pc), taken, flush);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
